// File: rtl/sdspi_bench_pkg.sv
// Shared types and default widths for the SD-SPI performance bench sequencer.
package sdspi_bench_pkg;

  localparam int N_BLOCK_SIZE    = 32;
  localparam int SCLK_SPEED_SIZE = 5;

  typedef enum logic [2:0] {
    IDLE,
    GUARD,
    START,
    RUN,
    REPORT,
    DONE
  } state_t;

  typedef enum logic [1:0] {
    ST_OK      = 2'b00,
    ST_ERR     = 2'b01,
    ST_TIMEOUT = 2'b10,
    ST_CFG     = 2'b11
  } status_t;

endpackage

// File: rtl/sdspi_bench_counter.sv
// Loadable up-counter with a terminal-count flag; reloaded whenever its owner is idle.
module sdspi_bench_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             en,
  input  logic [WIDTH-1:0] limit,
  output logic [WIDTH-1:0] count,
  output logic             at_limit
);

  always_ff @(posedge clk) begin
    if (load) begin
      count <= load_value;
    end else if (en) begin
      count <= count + WIDTH'(1);
    end
  end

  assign at_limit = (count == limit);

endmodule

// File: rtl/sdspi_bench_sequencer.sv
// Sweeps sdspi_system runs over a range of sclk_speed codes, timing each run
// and streaming one ready/valid result record per run.
module sdspi_bench_sequencer
  import sdspi_bench_pkg::*;
#(
  parameter int N_BLOCK_SIZE    = sdspi_bench_pkg::N_BLOCK_SIZE,
  parameter int SCLK_SPEED_SIZE = sdspi_bench_pkg::SCLK_SPEED_SIZE,
  parameter int CNT_WIDTH       = 32,
  parameter int TIMEOUT_CYCLES  = 100_000_000,
  parameter int GUARD_CYCLES    = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       go,
  input  logic [N_BLOCK_SIZE-1:0]    cfg_n_blocks,
  input  logic [SCLK_SPEED_SIZE-1:0] cfg_speed_first,
  input  logic [SCLK_SPEED_SIZE-1:0] cfg_speed_last,
  input  logic                       cfg_cmd18,
  output logic                       uut_rst,
  output logic                       uut_start,
  output logic [N_BLOCK_SIZE-1:0]    uut_n_blocks,
  output logic [SCLK_SPEED_SIZE-1:0] uut_sclk_speed,
  output logic                       uut_cmd18,
  input  logic                       uut_busy,
  input  logic                       uut_finish,
  input  logic                       uut_err,
  output logic                       ctrl_mux,
  output logic                       res_valid,
  input  logic                       res_ready,
  output logic [SCLK_SPEED_SIZE-1:0] res_speed,
  output logic [CNT_WIDTH-1:0]       res_cycles,
  output logic [1:0]                 res_status,
  output logic                       busy,
  output logic                       done
);

  localparam int GW = $clog2(GUARD_CYCLES) + 1;

  state_t                     state, state_next;
  status_t                    run_status;
  logic                       run_term;
  logic                       xfer;
  logic [SCLK_SPEED_SIZE-1:0] speed, speed_last;
  logic [GW-1:0]              guard_count;
  logic                       guard_tc;
  logic [CNT_WIDTH-1:0]       run_count;
  logic                       run_tc;
  logic                       uut_busy_unused;

  assign uut_busy_unused = uut_busy;
  assign xfer            = res_valid && res_ready;
  assign uut_sclk_speed  = speed;

  sdspi_bench_counter #(.WIDTH(GW)) u_guard_cnt (
    .clk        (clk),
    .load       (state != GUARD),
    .load_value ('0),
    .en         (state == GUARD),
    .limit      (GW'(GUARD_CYCLES - 1)),
    .count      (guard_count),
    .at_limit   (guard_tc)
  );

  // run_count is zero in the first RUN cycle, so at_limit marks the TIMEOUT_CYCLES-th cycle
  sdspi_bench_counter #(.WIDTH(CNT_WIDTH)) u_run_cnt (
    .clk        (clk),
    .load       (state != RUN),
    .load_value ('0),
    .en         (state == RUN),
    .limit      (CNT_WIDTH'(TIMEOUT_CYCLES - 1)),
    .count      (run_count),
    .at_limit   (run_tc)
  );

  always_comb begin
    run_term   = 1'b0;
    run_status = ST_OK;
    if (uut_err) begin
      run_term   = 1'b1;
      run_status = ST_ERR;
    end else if (uut_finish) begin
      run_term   = 1'b1;
      run_status = ST_OK;
    end else if (run_tc) begin
      run_term   = 1'b1;
      run_status = ST_TIMEOUT;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (go) state_next = (cfg_speed_first > cfg_speed_last) ? REPORT : GUARD;
      GUARD:   if (guard_tc) state_next = START;
      START:   state_next = RUN;
      RUN:     if (run_term) state_next = REPORT;
      REPORT:  if (xfer) state_next = (res_status == ST_CFG || speed == speed_last) ? DONE : GUARD;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Pin-mux select and UUT reset both derive from the next state, so they flip together
  always_ff @(posedge clk) begin
    if (!rst) begin
      uut_rst   <= 1'b1;
      uut_start <= 1'b0;
      ctrl_mux  <= 1'b0;
      res_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      uut_rst   <= !(state_next == START || state_next == RUN);
      ctrl_mux  <= (state_next == START || state_next == RUN);
      uut_start <= (state_next == START);
      res_valid <= (state_next == REPORT);
      busy      <= !(state_next == IDLE || state_next == DONE);
      done      <= (state_next == DONE);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      speed        <= '0;
      speed_last   <= '0;
      uut_n_blocks <= '0;
      uut_cmd18    <= 1'b0;
      res_speed    <= '0;
      res_cycles   <= '0;
      res_status   <= ST_OK;
    end else begin
      if (state == IDLE && go) begin
        speed        <= cfg_speed_first;
        speed_last   <= cfg_speed_last;
        uut_n_blocks <= cfg_n_blocks;
        uut_cmd18    <= cfg_cmd18;
        if (cfg_speed_first > cfg_speed_last) begin
          res_speed  <= cfg_speed_first;
          res_cycles <= '0;
          res_status <= ST_CFG;
        end
      end
      if (state == RUN && run_term) begin
        res_speed  <= speed;
        res_cycles <= run_count + CNT_WIDTH'(1);
        res_status <= run_status;
      end
      if (state == REPORT && xfer && state_next == GUARD) begin
        speed <= speed + SCLK_SPEED_SIZE'(1);
      end
    end
  end

endmodule

// File: tb/tb_sdspi_bench_sequencer.sv
// Scoreboard bench for sdspi_bench_sequencer with a behavioural UUT model and random backpressure.
module tb_sdspi_bench_sequencer;

  localparam int NB = 32;
  localparam int SW = 5;
  localparam int CW = 32;
  localparam int TO = 1200;
  localparam int GC = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          go = 1'b0;
  logic [NB-1:0] cfg_n_blocks = '0;
  logic [SW-1:0] cfg_speed_first = '0;
  logic [SW-1:0] cfg_speed_last = '0;
  logic          cfg_cmd18 = 1'b0;
  logic          uut_rst, uut_start, uut_cmd18, ctrl_mux, res_valid, busy, done;
  logic [NB-1:0] uut_n_blocks;
  logic [SW-1:0] uut_sclk_speed, res_speed;
  logic [CW-1:0] res_cycles;
  logic [1:0]    res_status;
  logic          uut_busy = 1'b0;
  logic          uut_finish = 1'b0;
  logic          uut_err = 1'b0;
  logic          res_ready = 1'b0;

  always #5 clk = ~clk;

  sdspi_bench_sequencer #(
    .N_BLOCK_SIZE(NB), .SCLK_SPEED_SIZE(SW), .CNT_WIDTH(CW),
    .TIMEOUT_CYCLES(TO), .GUARD_CYCLES(GC)
  ) dut (
    .clk(clk), .rst(rst), .go(go),
    .cfg_n_blocks(cfg_n_blocks), .cfg_speed_first(cfg_speed_first),
    .cfg_speed_last(cfg_speed_last), .cfg_cmd18(cfg_cmd18),
    .uut_rst(uut_rst), .uut_start(uut_start), .uut_n_blocks(uut_n_blocks),
    .uut_sclk_speed(uut_sclk_speed), .uut_cmd18(uut_cmd18),
    .uut_busy(uut_busy), .uut_finish(uut_finish), .uut_err(uut_err),
    .ctrl_mux(ctrl_mux), .res_valid(res_valid), .res_ready(res_ready),
    .res_speed(res_speed), .res_cycles(res_cycles), .res_status(res_status),
    .busy(busy), .done(done)
  );

  // kind: 0 finish, 1 err, 2 err+finish together, 3 never ends
  typedef struct {int speed; int cycles; int status;} rec_t;
  typedef struct {int kind; int n; int speed;} beh_t;

  rec_t          exp_q[$];
  beh_t          beh_q[$];
  beh_t          plan_q[$];
  int            checks = 0;
  int            errors = 0;
  int            starts = 0;
  int            ready_mode = 0;
  int            stall = 0;
  int            stall_last = 0;
  int            guard_run = 0;
  logic [NB-1:0] exp_nb = '0;
  logic          exp_cmd18 = 1'b0;

  task automatic check(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
    end
  endtask

  // Reference: a run ends at its own event unless the timeout is reached first
  function automatic rec_t expect_run(input beh_t b);
    rec_t r;
    r.speed = b.speed;
    if (b.kind == 3 || b.n > TO) begin
      r.cycles = TO;
      r.status = 2;
    end else begin
      r.cycles = b.n;
      r.status = (b.kind == 0) ? 0 : 1;
    end
    return r;
  endfunction

  task automatic add_plan(input int kind, input int n);
    beh_t b;
    b.kind = kind;
    b.n = (kind == 3) ? 2 * TO : n;
    b.speed = 0;
    plan_q.push_back(b);
  endtask

  task automatic rand_plan(input int count);
    for (int i = 0; i < count; i++) begin
      int k;
      k = $urandom_range(0, 9);
      add_plan(k <= 5 ? 0 : (k <= 7 ? 1 : (k == 8 ? 2 : 3)), $urandom_range(1, 400));
    end
  endtask

  task automatic sweep(input int first, input int last, input bit inject_go);
    int   nstart0, nrun;
    bit   seen;
    rec_t r;
    exp_nb = $urandom;
    exp_cmd18 = 1'($urandom_range(0, 1));
    if (first > last) begin
      r.speed = first; r.cycles = 0; r.status = 3;
      exp_q.push_back(r);
      nrun = 0;
    end else begin
      nrun = last - first + 1;
      for (int i = 0; i < nrun; i++) begin
        beh_t b;
        b = plan_q[i];
        b.speed = first + i;
        beh_q.push_back(b);
        exp_q.push_back(expect_run(b));
      end
    end
    plan_q.delete();
    nstart0 = starts;
    @(negedge clk);
    cfg_n_blocks = exp_nb; cfg_cmd18 = exp_cmd18;
    cfg_speed_first = SW'(first); cfg_speed_last = SW'(last);
    go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    cfg_n_blocks = $urandom; cfg_cmd18 = ~exp_cmd18;
    cfg_speed_first = SW'($urandom); cfg_speed_last = SW'($urandom);
    check("busy_after_go", busy, 1);
    if (inject_go) begin
      repeat (60) @(negedge clk);
      cfg_speed_first = 0; cfg_speed_last = 31; go = 1'b1;
      @(negedge clk);
      go = 1'b0;
    end
    seen = 0;
    for (int c = 0; c < 20000 && !seen; c++) begin
      @(negedge clk);
      if (done) seen = 1;
    end
    check("done_seen", seen, 1);
    if (seen) begin
      check("busy_at_done", busy, 0);
      check("records_left", exp_q.size(), 0);
      check("uut_starts", starts - nstart0, nrun);
      @(negedge clk);
      check("done_one_cycle", done, 0);
      check("busy_after_done", busy, 0);
    end else begin
      exp_q.delete();
      beh_q.delete();
      rst = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
    end
  endtask

  // Backpressure: 0 always ready, 1 random, 2 hold off for 20 valid cycles
  initial begin
    int hold;
    hold = 0;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0: begin res_ready = 1'b1; hold = 0; end
        1: begin res_ready = ($urandom_range(0, 2) != 0); hold = 0; end
        default: begin
          if (res_valid) hold++;
          res_ready = (hold > 20);
        end
      endcase
    end
  end

  // UUT model: consumes one planned behaviour per start pulse
  initial begin
    beh_t b;
    bit   aborted;
    forever begin
      @(negedge clk);
      if (uut_start && rst) begin
        if (beh_q.size() == 0) begin
          check("unplanned_start", 1, 0);
        end else begin
          b = beh_q.pop_front();
          check("uut_sclk_speed", uut_sclk_speed, b.speed);
          check("uut_n_blocks", uut_n_blocks, exp_nb);
          check("uut_cmd18", uut_cmd18, exp_cmd18);
          uut_busy = 1'b1;
          aborted = 0;
          for (int k = 1; k <= b.n && !aborted; k++) begin
            @(negedge clk);
            if (uut_rst) aborted = 1;
          end
          if (!aborted && b.kind != 3) begin
            uut_finish = (b.kind == 0 || b.kind == 2);
            uut_err = (b.kind == 1 || b.kind == 2);
            @(negedge clk);
            uut_finish = 1'b0;
            uut_err = 1'b0;
          end
          uut_busy = 1'b0;
        end
      end
    end
  end

  // Monitor: pops the scoreboard on each transfer and checks protocol invariants
  initial begin
    logic          pv, pr, prst;
    logic [SW-1:0] ps;
    logic [CW-1:0] pc;
    logic [1:0]    pst;
    rec_t          r;
    pv = 0; pr = 0; prst = 0; ps = '0; pc = '0; pst = '0;
    forever begin
      @(negedge clk);
      if (rst && prst) begin
        if (pv && !pr) begin
          check("hold_valid", res_valid, 1);
          check("hold_speed", res_speed, ps);
          check("hold_cycles", res_cycles, pc);
          check("hold_status", res_status, pst);
        end
        if (res_valid) begin
          check("valid_uut_rst", uut_rst, 1);
          check("valid_ctrl_mux", ctrl_mux, 0);
        end
        check("mux_vs_uut_rst", ctrl_mux, !uut_rst);
        if (uut_start) begin
          starts++;
          check("start_uut_rst", uut_rst, 0);
          check("guard_cycles", guard_run, GC);
        end
        if (res_valid && res_ready) begin
          stall_last = stall;
          if (exp_q.size() == 0) begin
            check("unexpected_record", 1, 0);
          end else begin
            r = exp_q.pop_front();
            check("res_speed", res_speed, r.speed);
            check("res_cycles", res_cycles, r.cycles);
            check("res_status", res_status, r.status);
          end
        end
      end
      stall = (res_valid && !res_ready) ? stall + 1 : 0;
      if (!uut_rst || !busy) guard_run = 0;
      else if (!res_valid) guard_run++;
      pv = res_valid; pr = res_ready; ps = res_speed; pc = res_cycles; pst = res_status;
      prst = rst;
    end
  end

  initial begin
    bit seen;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_uut_rst", uut_rst, 1);
    check("rst_uut_start", uut_start, 0);
    check("rst_ctrl_mux", ctrl_mux, 0);
    check("rst_res_valid", res_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_res_speed", res_speed, 0);
    check("rst_res_cycles", res_cycles, 0);
    check("rst_res_status", res_status, 0);
    check("rst_uut_n_blocks", uut_n_blocks, 0);
    check("rst_uut_sclk_speed", uut_sclk_speed, 0);
    check("rst_uut_cmd18", uut_cmd18, 0);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_uut_rst", uut_rst, 1);

    ready_mode = 0;
    repeat (3) add_plan(0, 1000);
    sweep(3, 5, 1);

    add_plan(2, 50);
    add_plan(0, 30);
    sweep(7, 8, 0);

    add_plan(3, 0);
    sweep(2, 2, 0);

    add_plan(0, TO);
    add_plan(1, TO + 1);
    sweep(20, 21, 0);

    sweep(9, 2, 0);

    ready_mode = 2;
    add_plan(0, 40);
    sweep(31, 31, 0);
    check("stall_cycles", stall_last, 20);
    ready_mode = 0;

    // Reset in the middle of a run drops the sweep without a record
    repeat (3) add_plan(3, 0);
    for (int i = 0; i < 3; i++) begin
      beh_t b;
      b = plan_q[i];
      b.speed = 10 + i;
      beh_q.push_back(b);
    end
    plan_q.delete();
    exp_nb = '0; exp_cmd18 = 1'b0;
    @(negedge clk);
    cfg_n_blocks = '0; cfg_cmd18 = 1'b0; cfg_speed_first = 10; cfg_speed_last = 12; go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    seen = 0;
    for (int c = 0; c < 100 && !seen; c++) begin
      @(negedge clk);
      if (ctrl_mux) seen = 1;
    end
    check("run_reached", seen, 1);
    repeat (30) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("midrun_uut_rst", uut_rst, 1);
    check("midrun_ctrl_mux", ctrl_mux, 0);
    check("midrun_res_valid", res_valid, 0);
    check("midrun_busy", busy, 0);
    check("midrun_uut_start", uut_start, 0);
    rst = 1'b1;
    beh_q.delete();
    repeat (5) @(negedge clk);
    check("after_rst_ctrl_mux", ctrl_mux, 0);
    check("after_rst_busy", busy, 0);
    check("after_rst_valid", res_valid, 0);
    check("after_rst_records", exp_q.size(), 0);

    ready_mode = 1;
    for (int s = 0; s < 6; s++) begin
      int first, len;
      first = $urandom_range(0, 28);
      len = $urandom_range(1, 4);
      rand_plan(len);
      sweep(first, first + len - 1, 0);
    end
    sweep(17, 16, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sdspi_bench_sequencer.md
Name: sdspi_bench_sequencer

Overview:
Autonomous sweep controller for the SD-SPI performance bench. It sequences sdspi_system runs across a range of sclk_speed settings, resetting and starting the unit under test (UUT) for each speed. It owns the SPI pin-mux select, times each run in clk cycles, and streams one result record per run to a ready/valid consumer such as the autotest/debug logic. It sits between the bench top-level and sdspi_system, alongside the SPI pin muxes.

Parameters:
N_BLOCK_SIZE, 32, width of the n_blocks configuration
SCLK_SPEED_SIZE, 5, width of the sclk_speed code
CNT_WIDTH, 32, width of the run cycle counter
TIMEOUT_CYCLES, 100_000_000, maximum run length in clk cycles before a run is aborted
GUARD_CYCLES, 16, UUT reset hold / SPI-pin quiet time between runs

Ports:
clk  in  1  system clock, the single clock domain
rst  in  1  synchronous reset, active-low
go  in  1  start a sweep; sampled only in IDLE
cfg_n_blocks  in  N_BLOCK_SIZE  blocks per run; captured on go
cfg_speed_first  in  SCLK_SPEED_SIZE  first speed code; captured on go
cfg_speed_last  in  SCLK_SPEED_SIZE  last speed code; captured on go
cfg_cmd18  in  1  multi-block read select; captured on go
uut_rst  out  1  UUT reset, active-high
uut_start  out  1  UUT start pulse
uut_n_blocks  out  N_BLOCK_SIZE  UUT block count (registered copy)
uut_sclk_speed  out  SCLK_SPEED_SIZE  current speed code
uut_cmd18  out  1  UUT cmd18 select (registered copy)
uut_busy  in  1  UUT busy
uut_finish  in  1  UUT finished
uut_err  in  1  UUT error
ctrl_mux  out  1  1 = UUT drives cs/sclk/mosi; 0 = bench drives them
res_valid  out  1  result record valid
res_ready  in  1  consumer accepts the record
res_speed  out  SCLK_SPEED_SIZE  speed code of the record
res_cycles  out  CNT_WIDTH  run length in cycles
res_status  out  2  00 ok, 01 err, 10 timeout, 11 config error
busy  out  1  sweep in progress
done  out  1  one-cycle pulse when the sweep completes

Behaviour:
- Reset (rst=0 at a clk edge):
  - State goes to IDLE.
  - uut_rst=1, uut_start=0, ctrl_mux=0, res_valid=0, busy=0, done=0.
  - res_*, uut_n_blocks, uut_sclk_speed, uut_cmd18 all clear to 0.
  - A reset during a run aborts the run; no record is emitted.
- IDLE:
  - uut_rst=1, ctrl_mux=0.
  - On go=1: capture all cfg_*, set speed=cfg_speed_first, busy=1.
  - If cfg_speed_first > cfg_speed_last: go to REPORT with status 11, cycles 0, and no UUT run.
  - Otherwise go to GUARD.
  - go is ignored in every state except IDLE.
- GUARD:
  - uut_rst=1, ctrl_mux=0, guard counter runs GUARD_CYCLES cycles, then go to START.
- START:
  - Exactly one cycle: uut_rst=0, uut_start=1, ctrl_mux=1, cycle counter cleared to 0.
  - Go to RUN.
- RUN:
  - ctrl_mux=1, uut_rst=0; the counter increments every cycle.
  - res_cycles equals the number of RUN cycles up to and including the cycle in which the terminating event is seen.
  - Terminating events, in priority order:
    - uut_err → status 01
    - uut_finish → status 00
    - counter reaching TIMEOUT_CYCLES → status 10
  - If err and finish assert in the same cycle, status is 01.
  - On any terminating event go to REPORT.
- REPORT:
  - Entry actions: ctrl_mux=0, uut_rst=1.
  - Record registered: res_valid=1, res_speed=speed, res_cycles, res_status.
  - Record is held stable until res_ready=1 (transfer on valid&&ready).
  - res_ready asserted at entry gives a one-cycle transfer.
- After transfer:
  - If status is 11, or speed==cfg_speed_last: go to DONE.
  - Otherwise speed+1 and go to GUARD.
  - No wrap-around: the last code, including all-ones, terminates the sweep.
- DONE:
  - done=1 for one cycle, busy=0, then go to IDLE.
- Outputs are registered; uut_start is never high outside START.
- ctrl_mux switches only while uut_rst=1, so the UUT never drives the SPI pins while in reset.

Decomposition:
- Package sdspi_bench_pkg holds:
  - state_t enum: IDLE, GUARD, START, RUN, REPORT, DONE
  - status_t codes: ST_OK, ST_ERR, ST_TIMEOUT, ST_CFG
  - default widths: N_BLOCK_SIZE, SCLK_SPEED_SIZE
- One sub-module, sdspi_bench_counter: a loadable up-counter with a terminal-count flag, instantiated once for the guard count and once for the run cycles/timeout.

Test Plan:
- Sweep 3..5, n_blocks=4, UUT model finishes 1000 cycles after start → three records (speed 3,4,5), status 00, cycles 1000, then done pulse; GUARD_CYCLES uut_rst-high cycles between runs.
- Model asserts uut_err and uut_finish in the same cycle at speed 7 → record status 01, sweep continues to the next speed.
- Model never finishes, TIMEOUT_CYCLES=500 → status 10, res_cycles=500, ctrl_mux=0 the cycle after.
- first=9, last=2 → single record, status 11, cycles 0; uut_start never pulses; done pulse.
- res_ready held low 20 cycles → res_* stable and uut_rst=1 throughout; first=last=31 → one run, no wrap to 0.
- rst=0 mid-RUN → next cycle uut_rst=1, ctrl_mux=0, res_valid=0, busy=0; go applied during a sweep is ignored.
